adc_event_capture_ctrl: RTL and testbench

- Sequences event acquisition on the ADC channel-A sample stream clocked by CLOCK_65. It arms, keeps a pre-trigger history, detects a rising threshold crossing (a particle pulse), captures post-trigger samples, then streams the whole event window out over a valid/ready handshake.
- Sits between the HSMC ADC input register and downstream pulse processing or host readout logic.
- Owns the capture buffer and all dead-time scheduling.

---
 rtl/adc_event_capture_ctrl_if.sv | 23 ++
 rtl/adc_event_capture_ctrl.sv | 153 +++++++++++++++
 tb/tb_adc_event_capture_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_event_capture_ctrl_if.sv
// Event sample stream: valid/ready handshake with an end-of-event marker.
interface adc_event_capture_ctrl_if #(
  parameter int DATA_W = 14
);
  logic [DATA_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_LAST;

  modport master (
    output OUT_DATA,
    output OUT_VALID,
    output OUT_LAST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_DATA,
    input  OUT_VALID,
    input  OUT_LAST,
    output OUT_READY
  );
endinterface

// File: rtl/adc_event_capture_ctrl.sv
// ADC channel-A event capture: pre-trigger history ring buffer, rising
// threshold trigger, post-trigger capture, then streamed readout of the whole
// window followed by a hold-off before re-arming.
module adc_event_capture_ctrl #(
  parameter int DATA_W  = 14,
  parameter int PRE     = 16,
  parameter int POST    = 48,
  parameter int HOLDOFF = 8
) (
  input  logic                     CLOCK_65,
  input  logic                     RESET,
  input  logic [DATA_W-1:0]        ADC_DA,
  input  logic                     ADC_OTR_A,
  input  logic                     ARM,
  input  logic [DATA_W-1:0]        THRESH,
  adc_event_capture_ctrl_if.master out_if,
  output logic                     BUSY,
  output logic [15:0]              EVENT_COUNT,
  output logic                     OTR_SEEN
);
  localparam int DEPTH = PRE + POST;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(PRE + 1);
  localparam int PW    = $clog2(POST + 1);
  localparam int HW    = $clog2(HOLDOFF + 1);
  localparam int CW    = AW + 1;

  localparam logic [FW-1:0] FILL_LAST = FW'(PRE - 1);
  localparam logic [PW-1:0] POST_LAST = PW'(POST - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
  localparam logic [CW-1:0] RD_END    = CW'(DEPTH);
  localparam logic [CW-1:0] RD_LAST   = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_A     = AW'(PRE);

  generate
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("adc_event_capture_ctrl: PRE+POST must be a power of two");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARMING, ST_ARMED, ST_CAPTURE, ST_READOUT, ST_HOLDOFF
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] samp_p0, samp_p1;
  logic              otr_p0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q_p1;
  logic              vld_p1, last_p1;

  logic [AW-1:0] wptr, trig_addr, raddr;
  logic [FW-1:0] fill_cnt;
  logic [PW-1:0] post_cnt;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] rd_cnt;
  logic          arm_q;

  logic wr_en, trig, cap_done, rd_fire, xfer_last, arm_rise;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only compared once ARMED, so both samples belong to the current history.
  assign trig      = (samp_p1 < THRESH) && (samp_p0 >= THRESH);
  assign wr_en     = (state == ST_ARMING) || (state == ST_ARMED) || (state == ST_CAPTURE);
  assign cap_done  = (state == ST_CAPTURE) && (post_cnt == POST_LAST);
  assign rd_fire   = (state == ST_READOUT) && (rd_cnt != RD_END) && (!vld_p1 || out_if.OUT_READY);
  assign xfer_last = vld_p1 && last_p1 && out_if.OUT_READY;
  assign arm_rise  = ARM && !arm_q;

  assign BUSY             = (state != ST_IDLE);
  assign out_if.OUT_VALID = vld_p1;
  assign out_if.OUT_LAST  = last_p1;
  assign out_if.OUT_DATA  = vld_p1 ? rd_q_p1 : '0;

  // State register.
  always_ff @(posedge CLOCK_65 or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a trigger in ARMED takes priority over ARM dropping.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (ARM) state_nxt = ST_ARMING;
      ST_ARMING:  if (!ARM) state_nxt = ST_IDLE;
                  else if (fill_cnt == FILL_LAST) state_nxt = ST_ARMED;
      ST_ARMED:   if (trig) state_nxt = ST_CAPTURE;
                  else if (!ARM) state_nxt = ST_IDLE;
      ST_CAPTURE: if (cap_done) state_nxt = ST_READOUT;
      ST_READOUT: if (xfer_last) state_nxt = ST_HOLDOFF;
      ST_HOLDOFF: if (hold_cnt == HOLD_LAST) state_nxt = ARM ? ST_ARMING : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Pointers, counters, stream control and status flags.
  always_ff @(posedge CLOCK_65 or posedge RESET) begin
    if (RESET) begin
      wptr        <= '0;
      trig_addr   <= '0;
      raddr       <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      hold_cnt    <= '0;
      rd_cnt      <= '0;
      vld_p1      <= 1'b0;
      last_p1     <= 1'b0;
      EVENT_COUNT <= '0;
      OTR_SEEN    <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      arm_q <= ARM;
      if (wr_en) wptr <= wptr + 1'b1;
      fill_cnt <= (state == ST_ARMING) ? fill_cnt + 1'b1 : '0;
      if ((state == ST_ARMED) && trig) begin
        trig_addr <= wptr;
        post_cnt  <= PW'(1);
      end else if (state == ST_CAPTURE) begin
        post_cnt <= post_cnt + 1'b1;
      end
      // Window start wraps naturally modulo DEPTH.
      if (cap_done)     raddr <= trig_addr - PRE_A;
      else if (rd_fire) raddr <= raddr + 1'b1;
      if (state != ST_READOUT) rd_cnt <= '0;
      else if (rd_fire)        rd_cnt <= rd_cnt + 1'b1;
      if (rd_fire) begin
        vld_p1  <= 1'b1;
        last_p1 <= (rd_cnt == RD_LAST);
      end else if (out_if.OUT_READY) begin
        vld_p1  <= 1'b0;
        last_p1 <= 1'b0;
      end
      hold_cnt <= (state == ST_HOLDOFF) ? hold_cnt + 1'b1 : '0;
      if (xfer_last) EVENT_COUNT <= sat_inc16(EVENT_COUNT);
      if (wr_en && otr_p0) OTR_SEEN <= 1'b1;
      else if (arm_rise)   OTR_SEEN <= 1'b0;
    end
  end

  // ---- p0: input register; p1: previous sample and buffer read ----
  always_ff @(posedge CLOCK_65) begin
    samp_p0 <= ADC_DA;
    samp_p1 <= samp_p0;
    otr_p0  <= ADC_OTR_A;
    if (wr_en)   mem[wptr] <= samp_p0;
    if (rd_fire) rd_q_p1   <= mem[raddr];
  end
endmodule

// File: tb/tb_adc_event_capture_ctrl.sv
// Directed bench for adc_event_capture_ctrl: table of ramp events plus
// hand-written sequences for no-trigger, ARM-drop, OTR and mid-event reset.
module tb_adc_event_capture_ctrl;
  localparam int DW = 14;

  logic          CLOCK_65 = 1'b0;
  logic          RESET = 1'b1;
  logic [DW-1:0] ADC_DA = '0;
  logic          ADC_OTR_A = 1'b0;
  logic          ARM = 1'b0;
  logic [DW-1:0] THRESH = '0;
  logic          BUSY;
  logic [15:0]   EVENT_COUNT;
  logic          OTR_SEEN;

  int n_cmp  = 0;
  int n_fail = 0;

  adc_event_capture_ctrl_if #(.DATA_W(DW)) out_if();

  adc_event_capture_ctrl #(
    .DATA_W(DW), .PRE(16), .POST(48), .HOLDOFF(8)
  ) dut (
    .CLOCK_65   (CLOCK_65),
    .RESET      (RESET),
    .ADC_DA     (ADC_DA),
    .ADC_OTR_A  (ADC_OTR_A),
    .ARM        (ARM),
    .THRESH     (THRESH),
    .out_if     (out_if),
    .BUSY       (BUSY),
    .EVENT_COUNT(EVENT_COUNT),
    .OTR_SEEN   (OTR_SEEN)
  );

  always #5 CLOCK_65 = ~CLOCK_65;

  typedef struct {
    logic          do_rst;
    logic [DW-1:0] base;
    logic [DW-1:0] thresh;
    int            rdy_mode;
    logic [DW-1:0] exp_first;
    logic [15:0]   exp_evcnt;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_65);
    #1;
  endtask

  function automatic logic rdy_of(input int mode, input int c);
    case (mode)
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return (c % 3) != 0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic apply_reset();
    RESET = 1'b1;
    ARM = 1'b0;
    ADC_OTR_A = 1'b0;
    out_if.OUT_READY = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  // Arms with a ramp ADC_DA = base + k (k = cycles since ARM rose), collects
  // the streamed window and checks it against base-derived expectations.
  task automatic run_event(input vec_t v, input string tag, input int arm_drop_k,
                           input int otr_k, input int abort_at);
    int k, nxf, cyc;
    logic stall;
    logic [DW-1:0] held;
    nxf = 0; cyc = 0; k = 0; stall = 1'b0; held = '0;
    THRESH = v.thresh;
    ADC_DA = v.base;
    ARM = 1'b1;
    out_if.OUT_READY = rdy_of(v.rdy_mode, 0);
    while (nxf < 64 && cyc < 3000 && !(abort_at >= 0 && nxf >= abort_at)) begin
      tick();
      cyc++;
      k++;
      if (stall) begin
        chk({tag, " stall valid"}, 32'(out_if.OUT_VALID), 32'd1);
        chk({tag, " stall data"}, 32'(out_if.OUT_DATA), 32'(held));
      end
      ADC_DA = DW'(v.base + k);
      ADC_OTR_A = (k == otr_k);
      if (k == arm_drop_k) ARM = 1'b0;
      out_if.OUT_READY = rdy_of(v.rdy_mode, cyc);
      if (out_if.OUT_VALID && out_if.OUT_READY) begin
        chk($sformatf("%s data[%0d]", tag, nxf), 32'(out_if.OUT_DATA), 32'(DW'(v.exp_first + nxf)));
        chk($sformatf("%s last[%0d]", tag, nxf), 32'(out_if.OUT_LAST), 32'(nxf == 63));
        nxf++;
      end
      stall = out_if.OUT_VALID && !out_if.OUT_READY;
      held  = out_if.OUT_DATA;
    end
    if (abort_at >= 0) begin
      chk({tag, " partial xfers"}, 32'(nxf), 32'(abort_at));
      return;
    end
    chk({tag, " xfer count"}, 32'(nxf), 32'd64);
    ARM = 1'b0;
    ADC_OTR_A = 1'b0;
    out_if.OUT_READY = 1'b1;
    tick();
    chk({tag, " valid after last"}, 32'(out_if.OUT_VALID), 32'd0);
    chk({tag, " event count"}, 32'(EVENT_COUNT), 32'(v.exp_evcnt));
    chk({tag, " busy in holdoff"}, 32'(BUSY), 32'd1);
    chk({tag, " otr seen"}, 32'(OTR_SEEN), 32'(otr_k >= 0));
    repeat (7) tick();
    chk({tag, " busy holdoff end"}, 32'(BUSY), 32'd1);
    tick();
    chk({tag, " idle after holdoff"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    logic [DW-1:0] nt_base[2];
    vec_t h;

    vecs[0] = '{1'b1, 14'h0F00, 14'h1000, 0, 14'h0FF0, 16'd1};
    vecs[1] = '{1'b0, 14'h0F00, 14'h1000, 1, 14'h0FF0, 16'd2};
    vecs[2] = '{1'b1, 14'h2000, 14'h2045, 0, 14'h2035, 16'd1};
    vecs[3] = '{1'b0, 14'h0000, 14'h0040, 2, 14'h0030, 16'd2};

    out_if.OUT_READY = 1'b1;
    tick();
    chk("rst valid", 32'(out_if.OUT_VALID), 32'd0);
    chk("rst last", 32'(out_if.OUT_LAST), 32'd0);
    chk("rst data", 32'(out_if.OUT_DATA), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst evcnt", 32'(EVENT_COUNT), 32'd0);
    chk("rst otr", 32'(OTR_SEEN), 32'd0);

    for (int i = 0; i < 4; i++) begin
      if (vecs[i].do_rst) apply_reset();
      run_event(vecs[i], $sformatf("v%0d", i), -1, -1, -1);
    end

    // Level already above threshold, or crossing while still filling history.
    nt_base[0] = 14'h1100;
    nt_base[1] = 14'h0FFB;
    for (int j = 0; j < 2; j++) begin
      apply_reset();
      THRESH = 14'h1000;
      ADC_DA = nt_base[j];
      ARM = 1'b1;
      vcnt = 0;
      for (int k = 1; k <= 150; k++) begin
        tick();
        ADC_DA = DW'(nt_base[j] + k);
        if (out_if.OUT_VALID) vcnt++;
      end
      chk($sformatf("notrig%0d valid seen", j), 32'(vcnt), 32'd0);
      chk($sformatf("notrig%0d busy", j), 32'(BUSY), 32'd1);
      ARM = 1'b0;
      tick();
      chk($sformatf("notrig%0d arm drop idle", j), 32'(BUSY), 32'd0);
    end

    // ARM dropped during capture, with one OTR pulse inside the window.
    apply_reset();
    h = '{1'b0, 14'h0500, 14'h0540, 0, 14'h0530, 16'd1};
    run_event(h, "capdrop", 69, 70, -1);
    tick();
    chk("otr sticky idle", 32'(OTR_SEEN), 32'd1);
    ARM = 1'b1;
    tick();
    chk("otr cleared on arm", 32'(OTR_SEEN), 32'd0);
    ARM = 1'b0;
    tick();
    tick();

    // Asynchronous reset in the middle of a readout.
    run_event(vecs[1], "abort", -1, -1, 10);
    RESET = 1'b1;
    #1;
    chk("abort valid", 32'(out_if.OUT_VALID), 32'd0);
    chk("abort data", 32'(out_if.OUT_DATA), 32'd0);
    chk("abort last", 32'(out_if.OUT_LAST), 32'd0);
    chk("abort busy", 32'(BUSY), 32'd0);
    chk("abort evcnt", 32'(EVENT_COUNT), 32'd0);
    ARM = 1'b0;
    out_if.OUT_READY = 1'b1;
    tick();
    RESET = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (out_if.OUT_VALID) vcnt++;
    end
    chk("post abort valid seen", 32'(vcnt), 32'd0);
    chk("post abort busy", 32'(BUSY), 32'd0);
    chk("post abort evcnt", 32'(EVENT_COUNT), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
